seven_seg_scan: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display, sitting directly downstream of the memory-mapped `seven_seg_lcd` peripheral. It consumes that peripheral's 32-bit `disp_o` word: four 8-bit active-high segment patterns, bit order dp-g-f-e-d-c-b-a. It scans one digit at a time and drives active-low anode and segment pins. Each digit's pattern is snapshotted at digit load, so software writes never tear a digit mid-display.

---
 rtl/seven_seg_pkg.sv | 24 ++
 rtl/seg_tick_gen.sv | 33 +++
 rtl/seven_seg_scan.sv | 105 ++++++++++
 tb/tb_seven_seg_scan.sv | 136 +++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scanner.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam int               NUM_DIGITS = 4;
  localparam logic [7:0]       SEG_OFF    = 8'hFF;
  localparam logic [3:0]       AN_OFF     = 4'hF;

  // Active-high segment pattern of digit idx (digit 0 = bits [7:0])
  function automatic logic [7:0] digit_pat(input logic [31:0] disp, input logic [1:0] idx);
    return disp[{idx, 3'b000} +: 8];
  endfunction

  // Active-low one-cold anode select for digit idx
  function automatic logic [NUM_DIGITS-1:0] an_sel(input logic [1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Modulo counter with synchronous clear and a terminal-count pulse.
// The terminal value is an input so one counter can time both the lit
// phase and the blanking phase.
module seg_tick_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == last_i);

  // Next count: clear wins, wrap to zero on terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (tc_o)  cnt_d = '0;
    else if (en_i)  cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit's pattern is captured at its load edge, so disp_i updates
// never tear a digit while it is lit.
// Optional: define SEG_DEADTIME_EN to insert DEAD_CYCLES all-off cycles
// between digits (anti-ghosting). Without it the handover is one edge.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] disp_i,
  output logic [3:0]  an_o,
  output logic [7:0]  seg_o
);

  localparam int CNT_MAX = (TICK_DIV > DEAD_CYCLES) ? TICK_DIV : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
`ifdef SEG_DEADTIME_EN
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
`endif

  scan_state_t      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick;
  logic [CNT_W-1:0] last;

  // Terminal value depends on which phase is being timed
`ifdef SEG_DEADTIME_EN
  assign last = (state_q == BLANK) ? DEAD_LAST : TICK_LAST;
`else
  assign last = TICK_LAST;
`endif

  seg_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q == LOAD),
    .en_i   (state_q != LOAD),
    .last_i (last),
    .tc_o   (tick)
  );

  // Scan FSM next-state, digit index and output pattern
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    an_d    = an_q;
    seg_d   = seg_q;
    case (state_q)
      LOAD: begin
        seg_d   = ~digit_pat(disp_i, idx_q);
        an_d    = an_sel(idx_q);
        state_d = SHOW;
      end
      SHOW: begin
        if (tick) begin
          idx_d = idx_q + 2'd1;
`ifdef SEG_DEADTIME_EN
          an_d    = AN_OFF;
          seg_d   = SEG_OFF;
          state_d = BLANK;
`else
          seg_d = ~digit_pat(disp_i, idx_q + 2'd1);
          an_d  = an_sel(idx_q + 2'd1);
`endif
        end
      end
`ifdef SEG_DEADTIME_EN
      BLANK: begin
        if (tick) begin
          seg_d   = ~digit_pat(disp_i, idx_q);
          an_d    = an_sel(idx_q);
          state_d = SHOW;
        end
      end
`endif
      default: state_d = LOAD;
    endcase
  end

  // State, index and registered pin drivers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      idx_q   <= 2'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with a time-based scoreboard model.
// Follows SEG_DEADTIME_EN if the build defines it.
module tb_seven_seg_scan;

  localparam int TICK = 4;
  localparam int DEAD = 2;
`ifdef SEG_DEADTIME_EN
  localparam int SLOT = TICK + DEAD;
`else
  localparam int SLOT = TICK;
`endif
  localparam int P = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp = 32'h777C713F;
  logic [3:0]  an;
  logic [7:0]  seg;

  int tests = 0;
  int fails = 0;
  int t = 0;              // non-reset edges since last reset
  bit armed = 1'b0;
  logic [7:0]  snap [4];
  logic [11:0] exp_q [$];

  seven_seg_scan #(.TICK_DIV(TICK), .DEAD_CYCLES(DEAD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .disp_i (disp),
    .an_o   (an),
    .seg_o  (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed an/seg=%h expected %h", tag, obs, expv);
    end
  endtask

  // Push the expected outputs for the coming edge, clock it, pop and compare
  task automatic step(input string tag);
    int ph, d, w;
    logic [11:0] e, got;
    if (rst) begin
      t = 0;
      e = {4'hF, 8'hFF};
    end else begin
      t++;
      ph = (t - 1) % P;
      d  = ph / SLOT;
      w  = ph % SLOT;
      if (w < TICK) begin
        if (w == 0) snap[d] = disp[8*d +: 8];
        e = {~(4'b0001 << d), ~snap[d]};
      end else begin
        e = {4'hF, 8'hFF};
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s: scoreboard empty, observed %h expected entry", tag, {an, seg});
    end else begin
      got = exp_q.pop_front();
      check(tag, {an, seg}, got);
    end
  endtask

  // Output invariants over the whole run
  always @(negedge clk) begin
    if (armed) begin
      tests++;
      assert (($countones(~an) <= 1) && ((an != 4'hF) || (seg == 8'hFF))) else begin
        fails++;
        $error("FAIL invariant: observed an=%h seg=%h expected at most one lit, off=>seg FF", an, seg);
      end
    end
  end

  initial begin
    int guard;
    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) step("reset_hold");
    armed = 1'b1;
    rst = 1'b0;
    step("first_load");
    check("first_digit_lit", {an, seg}, {4'hE, 8'hC0});

    // Two full refresh periods of the scan sequence
    for (int i = 0; i < 2 * P; i++) step("scan");
    check("wrap_digit0", {an, seg}, {4'hE, 8'hC0});

    // Snapshot: change digit 0 mid-display
    guard = 0;
    while ((t % P) != 2 && guard < P) begin step("seek_mid0"); guard++; end
    disp[7:0] = 8'h4F;
    guard = 0;
    while (((t - 1) % P) != TICK - 1 && guard < P) begin step("snap_hold"); guard++; end
    check("snap_still_old", {an, seg}, {4'hE, 8'hC0});
    guard = 0;
    while ((t % P) != 1 && guard < P) begin step("snap_wait"); guard++; end
    check("snap_new", {an, seg}, {4'hE, 8'hB0});

    // Reset mid-operation: during digit 2, or during a blank gap
    guard = 0;
`ifdef SEG_DEADTIME_EN
    while (((t - 1) % P) != TICK && guard < P) begin step("seek_blank"); guard++; end
    check("in_blank", {an, seg}, {4'hF, 8'hFF});
`else
    while (((t - 1) % P) != 2 * SLOT + 1 && guard < P) begin step("seek_d2"); guard++; end
    check("in_digit2", {an, seg}, {4'hB, 8'h83});
`endif
    rst = 1'b1;
    step("mid_reset");
    check("mid_reset_off", {an, seg}, {4'hF, 8'hFF});
    rst = 1'b0;
    step("restart");
    check("restart_digit0", {an, seg}, {4'hE, 8'hB0});
    for (int i = 0; i < P + 2; i++) step("scan_after");

    // New data on every digit, observed after one refresh
    disp = 32'h06_5B_4F_66;
    for (int i = 0; i < 2 * P; i++) step("new_data");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
